// File: rtl/oled_frame_streamer_if.sv
// Byte-wide valid/full push stream from the frame streamer to the OLED SPI controller.
interface oled_frame_streamer_if;
  logic [7:0] out_data;
  logic       out_dc;
  logic       out_valid;
  logic       out_full;

  modport master (
    output out_data,
    output out_dc,
    output out_valid,
    input  out_full
  );

  modport slave (
    input  out_data,
    input  out_dc,
    input  out_valid,
    output out_full
  );
endinterface

// File: rtl/oled_frame_streamer.sv
// OLED frame streamer: on start, emits the SSD1306 horizontal-addressing header and then
// every framebuffer byte, reading a 1-cycle-latency RAM and pushing into the controller.
module oled_frame_streamer #(
  parameter int unsigned COLS  = 128,
  parameter int unsigned PAGES = 4,
  parameter int unsigned FB_AW = 9
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 fb_rd_en,
  output logic [FB_AW-1:0]     fb_addr,
  input  logic [7:0]           fb_rdata,
  oled_frame_streamer_if.master stream
);

  localparam logic [FB_AW-1:0] LastIdx = FB_AW'(COLS * PAGES - 1);
  localparam logic [7:0]       ColMax  = 8'(COLS - 1);
  localparam logic [7:0]       PageMax = 8'(PAGES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StFetch,
    StLatch,
    StPush,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       hdr_idx_q, hdr_idx_d;
  logic [FB_AW-1:0] byte_idx_q, byte_idx_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_dc_q, out_dc_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;

  // Set column range 0..COLS-1 and page range 0..PAGES-1 in horizontal addressing mode.
  function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = 8'h20;
      3'd1:    b = 8'h00;
      3'd2:    b = 8'h21;
      3'd3:    b = 8'h00;
      3'd4:    b = ColMax;
      3'd5:    b = 8'h22;
      3'd6:    b = 8'h00;
      default: b = PageMax;
    endcase
    return b;
  endfunction

  assign accept = out_valid_q && !stream.out_full;

  // State and output registers; outputs are registered so an offered byte holds until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      hdr_idx_q   <= 3'd0;
      byte_idx_q  <= '0;
      out_data_q  <= 8'h00;
      out_dc_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_idx_q   <= hdr_idx_d;
      byte_idx_q  <= byte_idx_d;
      out_data_q  <= out_data_d;
      out_dc_q    <= out_dc_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state sequencing: header bytes, then FETCH/LATCH/PUSH per framebuffer byte.
  always_comb begin
    state_d     = state_q;
    hdr_idx_d   = hdr_idx_q;
    byte_idx_d  = byte_idx_q;
    out_data_d  = out_data_q;
    out_dc_d    = out_dc_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d     = StHdr;
          hdr_idx_d   = 3'd0;
          byte_idx_d  = '0;
          out_data_d  = hdr_byte(3'd0);
          out_dc_d    = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      StHdr: begin
        if (accept) begin
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == 3'd7) begin
            out_valid_d = 1'b0;
            state_d     = StFetch;
          end else begin
            out_data_d = hdr_byte(hdr_idx_q + 3'd1);
          end
        end
      end
      StFetch: begin
        state_d = StLatch;
      end
      StLatch: begin
        out_data_d  = fb_rdata;
        out_dc_d    = 1'b1;
        out_valid_d = 1'b1;
        state_d     = StPush;
      end
      StPush: begin
        if (accept) begin
          out_valid_d = 1'b0;
          if (byte_idx_q == LastIdx) begin
            state_d = StFin;
          end else begin
            byte_idx_d = byte_idx_q + FB_AW'(1);
            state_d    = StFetch;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort drops any offered byte and returns to idle without a done pulse.
    if (abort && state_q != StIdle) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
  end

  // Status and RAM strobes decode directly from the state register.
  always_comb begin
    busy             = (state_q != StIdle);
    done             = (state_q == StFin);
    fb_rd_en         = (state_q == StFetch);
    fb_addr          = byte_idx_q;
    stream.out_data  = out_data_q;
    stream.out_dc    = out_dc_q;
    stream.out_valid = out_valid_q;
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Scoreboard bench for oled_frame_streamer: expected bytes are queued at start and popped on
// every accepted byte; timing, backpressure, start-while-busy, abort and async reset are checked.
module tb_oled_frame_streamer;
  localparam int unsigned COLS   = 128;
  localparam int unsigned PAGES  = 4;
  localparam int unsigned FB_AW  = 9;
  localparam int unsigned NBYTES = COLS * PAGES;
  localparam int          BUDGET = 4000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             fb_rd_en;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_rdata;
  logic [7:0]       mem [NBYTES];

  oled_frame_streamer_if bus ();

  oled_frame_streamer #(
    .COLS  (COLS),
    .PAGES (PAGES),
    .FB_AW (FB_AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .fb_rd_en (fb_rd_en),
    .fb_addr  (fb_addr),
    .fb_rdata (fb_rdata),
    .stream   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous framebuffer RAM, one cycle read latency.
  always @(posedge clk) if (fb_rd_en) fb_rdata <= mem[fb_addr];

  int               errors = 0;
  int               checks = 0;
  int               cyc = 0;
  int               hdr_seen = 0;
  int               data_seen = 0;
  int               done_cnt = 0;
  int               last_done_cyc = 0;
  int               start_cyc = 0;
  logic [FB_AW-1:0] last_addr = '0;
  logic [8:0]       exp_q [$];
  logic [8:0]       exp_b;
  logic [7:0]       hdr_ref [8] = '{8'h20, 8'h00, 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted byte is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
      if (fb_rd_en) last_addr = fb_addr;
      if (bus.out_valid && !bus.out_full && !abort) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_b = exp_q.pop_front();
          check_eq(bus.out_dc ? "data_byte" : "hdr_byte", 32'({bus.out_dc, bus.out_data}),
                   32'(exp_b));
          if (bus.out_dc) data_seen++;
          else hdr_seen++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, hdr_ref[i]});
    for (int i = 0; i < int'(NBYTES); i++) exp_q.push_back({1'b1, 8'(i)});
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_seen(input string tag, input bit is_data, input int target);
    int k = 0;
    while (((is_data ? data_seen : hdr_seen) < target) && k < BUDGET) begin
      @(posedge clk);
      k++;
    end
    #1;
    check_eq(tag, 32'(k < BUDGET), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int base = done_cnt;
    int k = 0;
    while (done_cnt == base && k < BUDGET) begin
      @(posedge clk);
      k++;
    end
    tick(3);
    check_eq(tag, 32'(done_cnt - base), 32'd1);
  endtask

  // Clean frame: header, all data bytes, done timing and last framebuffer address.
  task automatic run_full(input string tag);
    int hb = hdr_seen;
    int db = data_seen;
    push_frame();
    pulse_start();
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done({tag, "_done_once"});
    check_eq({tag, "_done_cycle"}, 32'(last_done_cyc - start_cyc), 32'd1545);
    check_eq({tag, "_last_addr"}, 32'(last_addr), 32'd511);
    check_eq({tag, "_hdr_count"}, 32'(hdr_seen - hb), 32'd8);
    check_eq({tag, "_data_count"}, 32'(data_seen - db), 32'(NBYTES));
    check_eq({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    check_eq({tag, "_idle"}, 32'({busy, bus.out_valid}), 32'd0);
  endtask

  initial begin
    int db;
    int dc;
    reset        = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    bus.out_full = 1'b0;
    for (int i = 0; i < int'(NBYTES); i++) mem[i] = 8'(i);

    tick(1);
    check_eq("rst_flags", 32'({busy, done, fb_rd_en, bus.out_valid, bus.out_dc}), 32'd0);
    check_eq("rst_data", 32'(bus.out_data), 32'd0);
    check_eq("rst_addr", 32'(fb_addr), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    run_full("f1");

    // Backpressure on data byte 5, then a start pulse mid-frame that must be ignored.
    db = data_seen;
    push_frame();
    pulse_start();
    wait_seen("bp_reach", 1'b1, db + 5);
    bus.out_full = 1'b1;
    tick(2);
    for (int i = 0; i < 20; i++) begin
      check_eq("bp_hold", 32'({bus.out_valid, bus.out_dc, bus.out_data, fb_rd_en}),
               32'({1'b1, 1'b1, 8'h05, 1'b0}));
      tick(1);
    end
    bus.out_full = 1'b0;
    wait_seen("busy_reach", 1'b1, db + 100);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check_eq("restart_busy", 32'(busy), 32'd1);
    wait_done("f2_done_once");
    check_eq("f2_data_count", 32'(data_seen - db), 32'(NBYTES));
    check_eq("f2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Abort while data byte 200 is offered.
    db = data_seen;
    dc = done_cnt;
    push_frame();
    pulse_start();
    wait_seen("abort_reach", 1'b1, db + 200);
    bus.out_full = 1'b1;
    tick(2);
    check_eq("abort_offered", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'd200}));
    abort = 1'b1;
    tick(1);
    abort        = 1'b0;
    bus.out_full = 1'b0;
    check_eq("abort_next", 32'({bus.out_valid, busy, fb_rd_en}), 32'd0);
    check_eq("abort_pending", 32'(exp_q.size()), 32'(NBYTES - 200));
    exp_q.delete();
    tick(5);
    check_eq("abort_no_done", 32'(done_cnt - dc), 32'd0);
    check_eq("abort_idle", 32'({busy, bus.out_valid}), 32'd0);

    // Start and abort together in idle: abort wins.
    start = 1'b1;
    abort = 1'b1;
    tick(1);
    start = 1'b0;
    abort = 1'b0;
    tick(2);
    check_eq("start_abort_idle", 32'({busy, bus.out_valid}), 32'd0);

    run_full("f4");

    // Asynchronous reset while header byte 3 is offered.
    dc = hdr_seen;
    push_frame();
    pulse_start();
    wait_seen("rst_reach", 1'b0, dc + 3);
    check_eq("rst_mid_busy", 32'({busy, bus.out_valid}), 32'd3);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_flags", 32'({busy, done, fb_rd_en, bus.out_valid, bus.out_dc}), 32'd0);
    check_eq("arst_data", 32'(bus.out_data), 32'd0);
    check_eq("arst_addr", 32'(fb_addr), 32'd0);
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    tick(2);

    run_full("f6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
